// File: rtl/branch_sequencer.sv
// rtl/branch_sequencer.sv - branch target sequencer: sign-extend, target calc, PC load, link write, flush.
// A taken branch walks EXT -> CALC -> LOAD -> FLUSH; a not-taken branch is absorbed in IDLE.
module branch_sequencer #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        br_valid,
  output logic        br_ready,
  input  logic [23:0] br_imm24,
  input  logic [31:0] br_pc,
  input  logic        br_link,
  input  logic        br_cond_pass,
  output logic [23:0] ext_imm24,
  input  logic [31:0] ext_imm32,
  output logic        pc_load,
  output logic [31:0] pc_target,
  output logic        lr_we,
  output logic [31:0] lr_data,
  output logic        flush,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXT,
    S_CALC,
    S_LOAD,
    S_FLUSH
  } state_t;

  localparam logic [3:0] CntLast = 4'(FLUSH_CYCLES - 1);

  state_t      state_q, state_d;
  logic [23:0] imm_q, imm_d;
  logic [31:0] pc_q, pc_d;
  logic        link_q, link_d;
  logic [31:0] ext_q, ext_d;
  logic [31:0] target_q, target_d;
  logic [31:0] lr_q, lr_d;
  logic [3:0]  cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      imm_q    <= '0;
      pc_q     <= '0;
      link_q   <= 1'b0;
      ext_q    <= '0;
      target_q <= '0;
      lr_q     <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      imm_q    <= imm_d;
      pc_q     <= pc_d;
      link_q   <= link_d;
      ext_q    <= ext_d;
      target_q <= target_d;
      lr_q     <= lr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    imm_d    = imm_q;
    pc_d     = pc_q;
    link_d   = link_q;
    ext_d    = ext_q;
    target_d = target_q;
    lr_d     = lr_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (br_valid) begin
          imm_d  = br_imm24;
          pc_d   = br_pc;
          link_d = br_link;
          if (br_cond_pass) state_d = S_EXT;
        end
      end
      S_EXT: begin
        ext_d   = ext_imm32;
        state_d = S_CALC;
      end
      S_CALC: begin
        // Offset is in words; the +8 models the two-instruction prefetch.
        target_d = pc_q + 32'd8 + (ext_q << 2);
        if (link_q) lr_d = pc_q + 32'd4;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Kept outside the next-state block so the external extender path is not a loop.
  assign ext_imm24 = (state_q == S_EXT) ? imm_q : 24'd0;
  assign br_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign pc_load   = (state_q == S_LOAD);
  assign lr_we     = (state_q == S_LOAD) && link_q;
  assign flush     = (state_q == S_FLUSH);
  assign pc_target = target_q;
  assign lr_data   = lr_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// tb/tb_branch_sequencer.sv - self-checking bench for branch_sequencer.
module tb_branch_sequencer;

  localparam int F = 2;

  typedef struct {
    logic [23:0] imm;
    logic [31:0] pc;
    logic        link;
    logic        cond;
    logic [31:0] tgt;
    logic [31:0] lr;
  } vec_t;

  typedef struct {
    int          cyc;
    logic        link;
    logic [31:0] tgt;
    logic [31:0] lr;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        br_valid, br_ready, br_link, br_cond_pass;
  logic [23:0] br_imm24, ext_imm24;
  logic [31:0] br_pc, ext_imm32, pc_target, lr_data;
  logic        pc_load, lr_we, flush, busy;

  logic        br_valid3, br_ready3, br_link3, br_cond_pass3;
  logic [23:0] br_imm24_3, ext_imm24_3;
  logic [31:0] br_pc3, ext_imm32_3, pc_target3, lr_data3;
  logic        pc_load3, lr_we3, flush3, busy3;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  exp_t sb[$];
  exp_t mon_e;
  int   last_load = -100;
  int   flush_run = 0;
  int   loads3 = 0;
  logic [31:0] tgt3 [4];
  logic        we3 [4];
  vec_t vecs [8];

  assign ext_imm32   = {{8{ext_imm24[23]}}, ext_imm24};
  assign ext_imm32_3 = {{8{ext_imm24_3[23]}}, ext_imm24_3};

  branch_sequencer #(.FLUSH_CYCLES(F)) dut (
    .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_ready(br_ready),
    .br_imm24(br_imm24), .br_pc(br_pc), .br_link(br_link), .br_cond_pass(br_cond_pass),
    .ext_imm24(ext_imm24), .ext_imm32(ext_imm32), .pc_load(pc_load), .pc_target(pc_target),
    .lr_we(lr_we), .lr_data(lr_data), .flush(flush), .busy(busy)
  );

  branch_sequencer #(.FLUSH_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .br_valid(br_valid3), .br_ready(br_ready3),
    .br_imm24(br_imm24_3), .br_pc(br_pc3), .br_link(br_link3), .br_cond_pass(br_cond_pass3),
    .ext_imm24(ext_imm24_3), .ext_imm32(ext_imm32_3), .pc_load(pc_load3), .pc_target(pc_target3),
    .lr_we(lr_we3), .lr_data(lr_data3), .flush(flush3), .busy(busy3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (pc_load) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_pc_load: got pc_load=1 at cycle %0d expected none", cyc);
        end else begin
          mon_e = sb.pop_front();
          chk("load_latency", cyc, mon_e.cyc + 3);
          chk("pc_target", pc_target, mon_e.tgt);
          chk("lr_we", {31'd0, lr_we}, {31'd0, mon_e.link});
          if (mon_e.link) chk("lr_data", lr_data, mon_e.lr);
        end
        last_load = cyc;
      end
      if (flush) begin
        flush_run++;
        if (cyc <= last_load || cyc > last_load + F) begin
          n_cmp++;
          n_err++;
          $display("FAIL flush_window: got flush at cycle %0d expected only %0d..%0d",
                   cyc, last_load + 1, last_load + F);
        end
      end else if (flush_run > 0) begin
        chk("flush_len", flush_run, F);
        flush_run = 0;
      end
    end else begin
      flush_run = 0;
    end
  end

  always @(negedge clk) begin
    if (rst_n && pc_load3) begin
      if (loads3 < 4) begin
        tgt3[loads3] = pc_target3;
        we3[loads3]  = lr_we3;
      end
      loads3++;
    end
  end

  task automatic send(input vec_t v, output int acc);
    int guard;
    br_imm24     = v.imm;
    br_pc        = v.pc;
    br_link      = v.link;
    br_cond_pass = v.cond;
    br_valid     = 1'b1;
    guard = 0;
    while (!br_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!br_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: got br_ready=0 for %0d cycles expected 1", guard);
      br_valid = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc;
    if (v.cond) begin
      exp_t e;
      e.cyc  = acc;
      e.link = v.link;
      e.tgt  = v.tgt;
      e.lr   = v.lr;
      sb.push_back(e);
    end
    @(negedge clk);
    br_valid     = 1'b0;
    br_imm24     = 24'($urandom);
    br_pc        = $urandom;
    br_link      = 1'($urandom);
    br_cond_pass = 1'($urandom);
    chk("busy_after_accept", {31'd0, busy}, {31'd0, v.cond});
    chk("ext_imm24", {8'd0, ext_imm24}, v.cond ? {8'd0, v.imm} : 32'd0);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((sb.size() != 0 || busy) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_queue", sb.size(), 0);
    chk("drain_busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_br_ready"}, {31'd0, br_ready}, 32'd1);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_pc_load"}, {31'd0, pc_load}, 32'd0);
    chk({tag, "_lr_we"}, {31'd0, lr_we}, 32'd0);
    chk({tag, "_flush"}, {31'd0, flush}, 32'd0);
    chk({tag, "_pc_target"}, pc_target, 32'd0);
    chk({tag, "_lr_data"}, lr_data, 32'd0);
    chk({tag, "_ext_imm24"}, {8'd0, ext_imm24}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int acc, prev_acc, rel, guard, c1, c2;
    logic prev_taken;
    vec_t v;

    vecs[0] = '{24'hFFFFFD, 32'h0000_0100, 1'b0, 1'b1, 32'h0000_00FC, 32'h0};
    vecs[1] = '{24'h000010, 32'h0000_1000, 1'b1, 1'b1, 32'h0000_1048, 32'h0000_1004};
    vecs[2] = '{24'h123456, 32'h0000_2000, 1'b1, 1'b0, 32'h0, 32'h0};
    vecs[3] = '{24'h000001, 32'hFFFF_FFF8, 1'b0, 1'b1, 32'h0000_0004, 32'h0};
    vecs[4] = '{24'h800000, 32'h1000_0000, 1'b1, 1'b1, 32'h0E00_0008, 32'h1000_0004};
    vecs[5] = '{24'h7FFFFF, 32'h0000_0000, 1'b0, 1'b0, 32'h0, 32'h0};
    vecs[6] = '{24'h7FFFFF, 32'h0000_0000, 1'b0, 1'b1, 32'h0200_0004, 32'h0};
    vecs[7] = '{24'h000000, 32'hFFFF_FFFC, 1'b1, 1'b1, 32'h0000_0004, 32'h0000_0000};

    br_valid = 0; br_imm24 = 0; br_pc = 0; br_link = 0; br_cond_pass = 0;
    br_valid3 = 0; br_imm24_3 = 0; br_pc3 = 0; br_link3 = 0; br_cond_pass3 = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk_reset_outputs("reset");
    chk("reset_br_ready3", {31'd0, br_ready3}, 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rel = cyc;

    prev_acc = 0;
    prev_taken = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send(vecs[i], acc);
      if (i == 0) chk("first_accept_after_reset", acc, rel);
      else chk("accept_spacing", acc - prev_acc, prev_taken ? (4 + F) : 1);
      prev_acc = acc;
      prev_taken = vecs[i].cond;
    end
    drain();

    // Reset during CALC aborts the branch without a clock edge.
    v = '{24'h000040, 32'h0000_4000, 1'b1, 1'b1, 32'h0000_4108, 32'h0000_4004};
    send(v, acc);
    @(negedge clk);
    void'(sb.pop_back());
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("abort");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort_no_pc_load", {31'd0, pc_load}, 32'd0);
      chk("abort_no_flush", {31'd0, flush}, 32'd0);
    end
    rst_n = 1'b1;
    rel = cyc;
    v = '{24'hFFFFFF, 32'h0000_0800, 1'b1, 1'b1, 32'h0000_0804, 32'h0000_0804};
    send(v, acc);
    chk("accept_after_abort", acc, rel);
    drain();

    // Held valid on the FLUSH_CYCLES=3 instance: two requests, seven cycles apart.
    br_imm24_3 = 24'h000004; br_pc3 = 32'h0000_0200; br_link3 = 1'b0; br_cond_pass3 = 1'b1;
    br_valid3 = 1'b1;
    guard = 0;
    while (!br_ready3 && guard < 50) begin @(negedge clk); guard++; end
    c1 = cyc;
    @(negedge clk);
    br_imm24_3 = 24'hFFFFFF; br_pc3 = 32'h0000_0300; br_link3 = 1'b1;
    guard = 0;
    while (!br_ready3 && guard < 50) begin @(negedge clk); guard++; end
    c2 = cyc;
    chk("b2b_spacing", c2 - c1, 7);
    @(negedge clk);
    br_valid3 = 1'b0;
    repeat (10) @(negedge clk);
    chk("b2b_loads", loads3, 2);
    chk("b2b_tgt_a", tgt3[0], 32'h0000_0218);
    chk("b2b_we_a", {31'd0, we3[0]}, 32'd0);
    chk("b2b_tgt_b", tgt3[1], 32'h0000_0304);
    chk("b2b_we_b", {31'd0, we3[1]}, 32'd1);
    chk("b2b_lr_b", lr_data3, 32'h0000_0304);
    chk("b2b_idle", {30'd0, busy3, flush3}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/branch_sequencer.md
BRANCH_SEQUENCER -- requirements
Module: branch_sequencer

Interface
REQ-001 Parameter: FLUSH_CYCLES, default 2, number of cycles flush is held high after a taken branch; legal range 1-15.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: br_valid  input  1  branch request present.
REQ-005 Port: br_ready  output  1  block can accept a request this cycle.
REQ-006 Port: br_imm24  input  24  raw 24-bit branch offset field, in words.
REQ-007 Port: br_pc  input  32  byte address of the branch instruction.
REQ-008 Port: br_link  input  1  request is branch-with-link.
REQ-009 Port: br_cond_pass  input  1  condition code check passed.
REQ-010 Port: ext_imm24  output  24  operand driven to the shared 24-to-32 sign-extend unit.
REQ-011 Port: ext_imm32  input  32  combinational result returned by the sign-extend unit.
REQ-012 Port: pc_load  output  1  one-cycle strobe; PC loads pc_target.
REQ-013 Port: pc_target  output  32  computed branch target.
REQ-014 Port: lr_we  output  1  one-cycle link-register write strobe.
REQ-015 Port: lr_data  output  32  return address for the link register.
REQ-016 Port: flush  output  1  pipeline flush request.
REQ-017 Port: busy  output  1  high whenever state is not IDLE.

Function
REQ-018 The block SHALL implement states IDLE, EXT, CALC, LOAD, FLUSH.
REQ-019 br_ready SHALL be 1 only in IDLE; a request is accepted when br_valid and br_ready are both 1 on a rising edge.
REQ-020 On accept, br_imm24, br_pc and br_link SHALL be latched; input changes after accept SHALL be ignored until the next accept.
REQ-021 On accept with br_cond_pass=0, the block SHALL remain in IDLE and assert no pc_load, lr_we or flush (not-taken, zero-cycle).
REQ-022 On accept with br_cond_pass=1, the block SHALL go IDLE->EXT.
REQ-023 In EXT, ext_imm24 SHALL equal the latched offset and ext_imm32 SHALL be registered at the end of the cycle; next state CALC. Outside EXT, ext_imm24 SHALL be 0.
REQ-024 In CALC, the block SHALL register pc_target = latched_pc + 8 + (ext_imm32 << 2), all modulo 2^32, with wrap-around discarded; next state LOAD.
REQ-025 In LOAD, pc_load SHALL be 1 for exactly one cycle; if the latched link is set, lr_we SHALL be 1 in the same cycle with lr_data = latched_pc + 4 (mod 2^32); next state FLUSH.
REQ-026 In FLUSH, flush SHALL be 1 for exactly FLUSH_CYCLES consecutive cycles, counted by an internal counter, then return to IDLE.
REQ-027 Latency: accept edge at cycle N gives pc_load high in cycle N+3, flush high in N+4 through N+3+FLUSH_CYCLES, and br_ready high again in N+4+FLUSH_CYCLES.
REQ-028 A br_valid held high through a busy period SHALL be accepted on the first IDLE cycle; back-to-back requests SHALL NOT be merged or dropped.
REQ-029 pc_target and lr_data SHALL hold their last values until overwritten; pc_load, lr_we, flush SHALL otherwise be 0.

Reset
REQ-030 While rst_n=0, state SHALL be IDLE, the flush counter 0, and every output 0 except br_ready=1, regardless of clk.
REQ-031 Reset asserted mid-sequence SHALL abort the branch immediately with no pc_load, lr_we or flush after assertion.
REQ-032 After rst_n deasserts, the first accept SHALL be possible on the next rising edge.

Verification
REQ-033 br_imm24=0xFFFFFD, br_pc=0x00000100, cond=1, link=0 -> ext_imm24=0xFFFFFD in N+1, pc_load=1 with pc_target=0x000000FC in N+3, lr_we=0, flush high for 2 cycles.
REQ-034 br_imm24=0x000010, br_pc=0x00001000, link=1 -> pc_target=0x00001048, lr_we=1 with lr_data=0x00001004 in the same cycle as pc_load.
REQ-035 br_cond_pass=0 with any offset -> br_ready stays 1 and no pc_load, lr_we or flush; the next request is accepted on the following cycle.
REQ-036 br_pc=0xFFFFFFF8, br_imm24=0x000001 -> pc_target=0x00000004 (wrap-around).
REQ-037 rst_n pulled low during CALC -> all outputs 0 and br_ready=1 without waiting for a clock edge, with no pc_load afterwards; a fresh request then completes normally.
REQ-038 br_valid held high for two requests with FLUSH_CYCLES=3 -> second accept exactly 7 cycles after the first, and both produce pc_load.
